// File: rtl/mm_pkg.sv
// Shared FSM encoding and datapath widths for the dot-product controller slice.
package mm_pkg;

    localparam int ACC_W = 32;
    localparam int LEN_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        GO,
        WAIT_DONE,
        CAP,
        ACK,
        WB,
        FIN
    } state_e;

endpackage

// File: rtl/mm_dp_controller_if.sv
// Engine-array handshake plus result-RAM write port of the dot-product controller.
interface mm_dp_controller_if #(
    parameter int NUM_DP = 4,
    parameter int PASS_W = 4
);
    import mm_pkg::*;

    localparam int ADDR_W = PASS_W + $clog2(NUM_DP);

    logic                    start_mm;
    logic [LEN_W-1:0]        a2;
    logic                    ack_ticks;
    logic [NUM_DP-1:0]       dp_done;
    logic [NUM_DP*ACC_W-1:0] acc_flat;
    logic [PASS_W-1:0]       pass_idx;
    logic                    res_we;
    logic [ADDR_W-1:0]       res_addr;
    logic [ACC_W-1:0]        res_data;

    modport master (
        output start_mm, a2, ack_ticks, pass_idx, res_we, res_addr, res_data,
        input  dp_done, acc_flat
    );

    modport slave (
        input  start_mm, a2, ack_ticks, pass_idx, res_we, res_addr, res_data,
        output dp_done, acc_flat
    );

endinterface

// File: rtl/mm_result_buffer.sv
// Per-pass capture of all engine results, read back one engine at a time for the RAM write.
module mm_result_buffer
    import mm_pkg::*;
#(
    parameter int NUM_DP = 4,
    parameter int PASS_W = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_i,
    input  logic [NUM_DP*ACC_W-1:0]          acc_flat_i,
    input  logic [PASS_W-1:0]                pass_idx_i,
    input  logic [$clog2(NUM_DP)-1:0]        k_i,
    output logic [PASS_W+$clog2(NUM_DP)-1:0] res_addr_o,
    output logic [ACC_W-1:0]                 res_data_o
);

    logic [ACC_W-1:0] cap_q [NUM_DP];

    // NOTE: this small register array is reset because a zero buffer is part of the
    // defined reset state; a real RAM-sized store would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DP; i++) cap_q[i] <= '0;
        end else if (load_i) begin
            for (int i = 0; i < NUM_DP; i++) cap_q[i] <= acc_flat_i[i*ACC_W +: ACC_W];
        end
    end

    // NUM_DP is a power of two, so concatenation equals pass_idx*NUM_DP + k.
    assign res_addr_o = {pass_idx_i, k_i};
    assign res_data_o = cap_q[k_i];

endmodule

// File: rtl/mm_dp_controller.sv
// Job sequencer for the dot-product engine array: start/collect/ack each pass, then
// stream the captured results into the result RAM.
module mm_dp_controller
    import mm_pkg::*;
#(
    parameter int NUM_DP  = 4,
    parameter int PASS_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [PASS_W-1:0] n_pass,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       ticks,
    mm_dp_controller_if.master bus
);

    localparam int K_W    = $clog2(NUM_DP);
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int ADDR_W = PASS_W + K_W;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    state_e            state_q,  state_d;
    logic [PASS_W-1:0] n_pass_q, n_pass_d;
    logic [LEN_W-1:0]  len_q,    len_d;
    logic [PASS_W-1:0] pass_q,   pass_d;
    logic [K_W-1:0]    k_q,      k_d;
    logic [TO_W-1:0]   wait_q,   wait_d;
    logic              err_q,    err_d;
    logic [31:0]       ticks_q,  ticks_d;

    logic              cap_load;
    logic [ADDR_W-1:0] res_addr_w;
    logic [ACC_W-1:0]  res_data_w;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // Asserts with reset_n immediately, releases two edges later.
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_pass_q <= '0;
            len_q    <= '0;
            pass_q   <= '0;
            k_q      <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
            ticks_q  <= '0;
        end else begin
            state_q  <= state_d;
            n_pass_q <= n_pass_d;
            len_q    <= len_d;
            pass_q   <= pass_d;
            k_q      <= k_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            ticks_q  <= ticks_d;
        end
    end

    // NOTE: every next-state variable gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        n_pass_d = n_pass_q;
        len_d    = len_q;
        pass_d   = pass_q;
        k_d      = k_q;
        wait_d   = wait_q;
        err_d    = err_q;
        ticks_d  = ticks_q;

        if (state_q != IDLE && ticks_q != '1) ticks_d = ticks_q + 32'd1;

        case (state_q)
            IDLE: begin
                if (go) begin
                    n_pass_d = n_pass;
                    len_d    = vec_len;
                    ticks_d  = '0;
                    err_d    = 1'b0;
                    pass_d   = '0;
                    k_d      = '0;
                    state_d  = (n_pass == '0) ? FIN : ARM;
                end
            end
            ARM: state_d = GO;
            GO: begin
                wait_d  = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (&bus.dp_done) begin
                    state_d = CAP;
                end else if (TIMEOUT != 0 && wait_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CAP: state_d = ACK;
            ACK: begin
                // Engines drop done once they see the ack; only then is the array idle.
                if (!(|bus.dp_done)) begin
                    k_d     = '0;
                    state_d = WB;
                end
            end
            WB: begin
                k_d = k_q + 1'b1;
                if (k_q == K_W'(NUM_DP - 1)) begin
                    if (pass_q == n_pass_q - 1'b1) begin
                        state_d = FIN;
                    end else begin
                        pass_d  = pass_q + 1'b1;
                        state_d = ARM;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cap_load = (state_q == CAP);

    mm_result_buffer #(
        .NUM_DP (NUM_DP),
        .PASS_W (PASS_W)
    ) u_result_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cap_load),
        .acc_flat_i (bus.acc_flat),
        .pass_idx_i (pass_q),
        .k_i        (k_q),
        .res_addr_o (res_addr_w),
        .res_data_o (res_data_w)
    );

    // Outputs are pure state decodes so an async reset clears them at once.
    assign bus.start_mm  = (state_q == GO) || (state_q == WAIT_DONE);
    assign bus.ack_ticks = (state_q == ACK);
    assign bus.res_we    = (state_q == WB);
    assign bus.a2        = len_q;
    assign bus.pass_idx  = pass_q;
    assign bus.res_addr  = res_addr_w;
    assign bus.res_data  = res_data_w;

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == FIN);
    assign err   = err_q;
    assign ticks = ticks_q;

endmodule

// File: tb/tb_mm_dp_controller.sv
// Directed bench for mm_dp_controller with behavioural engines and a write scoreboard.
module tb_mm_dp_controller;

    localparam int NUM_DP = 4;
    localparam int PASS_W = 4;

    logic        clk;
    logic        reset_n;
    logic        go;
    logic [3:0]  n_pass;
    logic [3:0]  vec_len;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] ticks;

    int total = 0;
    int bad   = 0;

    mm_dp_controller_if #(.NUM_DP(NUM_DP), .PASS_W(PASS_W)) bus ();

    mm_dp_controller #(
        .NUM_DP  (NUM_DP),
        .PASS_W  (PASS_W),
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (go),
        .n_pass  (n_pass),
        .vec_len (vec_len),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .ticks   (ticks),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- engine models with operand RAMs ----------------
    typedef enum logic [1:0] {E_IDLE, E_RUN, E_DONE} eng_e;

    logic [7:0]  a_mem [NUM_DP][16][16];
    logic [7:0]  b_mem [NUM_DP][16][16];
    int          delay [NUM_DP];
    bit          stuck [NUM_DP];
    bit          eng_clr;
    eng_e        est   [NUM_DP];
    int          cnt   [NUM_DP];
    logic [31:0] pend  [NUM_DP];
    logic [31:0] acc_m [NUM_DP];
    logic [3:0]  dp_done_m = '0;
    logic        prev_start;

    function automatic logic [31:0] dot(input int k, input int p, input int len);
        logic [31:0] s = '0;
        for (int i = 0; i < len; i++) s += 32'(a_mem[k][p][i]) * 32'(b_mem[k][p][i]);
        return s;
    endfunction

    always @(posedge clk) begin
        prev_start <= eng_clr ? 1'b0 : bus.start_mm;
        for (int k = 0; k < NUM_DP; k++) begin
            if (eng_clr) begin
                est[k]       <= E_IDLE;
                dp_done_m[k] <= 1'b0;
                acc_m[k]     <= '0;
            end else begin
                case (est[k])
                    E_IDLE: if (bus.start_mm && !prev_start) begin
                        pend[k]  <= dot(k, int'(bus.pass_idx), int'(bus.a2));
                        acc_m[k] <= 32'hDEAD_BEEF;
                        cnt[k]   <= int'(bus.a2) + delay[k];
                        est[k]   <= E_RUN;
                    end
                    E_RUN: if (cnt[k] == 0) begin
                        if (!stuck[k]) begin
                            dp_done_m[k] <= 1'b1;
                            acc_m[k]     <= pend[k];
                            est[k]       <= E_DONE;
                        end
                    end else begin
                        cnt[k] <= cnt[k] - 1;
                    end
                    E_DONE: if (bus.ack_ticks) begin
                        dp_done_m[k] <= 1'b0;
                        est[k]       <= E_IDLE;
                    end
                    default: est[k] <= E_IDLE;
                endcase
            end
        end
    end

    assign bus.dp_done  = dp_done_m;
    assign bus.acc_flat = {acc_m[3], acc_m[2], acc_m[1], acc_m[0]};

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  pass;
    } wr_t;

    wr_t sb[$];
    int  busy_cnt, start_rise, start_hi, ack_rise, we_cnt, stray;
    logic prev_start_m = 1'b0;
    logic prev_ack_m   = 1'b0;

    always @(negedge clk) begin
        wr_t e;
        if (busy === 1'b1) busy_cnt++;
        if (bus.start_mm === 1'b1) start_hi++;
        if (bus.start_mm === 1'b1 && !prev_start_m) start_rise++;
        if (bus.ack_ticks === 1'b1 && !prev_ack_m) ack_rise++;
        // A normal start_mm fall marks CAP: every engine must already be done.
        if (bus.start_mm === 1'b0 && prev_start_m && err === 1'b0 && reset_n === 1'b1)
            check("cap_after_all_done", 32'(&bus.dp_done), 32'd1);
        if (bus.res_we === 1'b1) begin
            we_cnt++;
            if (sb.size() == 0) begin
                stray++;
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus.res_addr), 32'(e.addr));
                check("wr_data", bus.res_data, e.data);
                check("wr_pass", 32'(bus.pass_idx), 32'(e.pass));
            end
        end
        prev_start_m = (bus.start_mm === 1'b1);
        prev_ack_m   = (bus.ack_ticks === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill(input int mode);
        for (int k = 0; k < NUM_DP; k++)
            for (int p = 0; p < 16; p++)
                for (int i = 0; i < 16; i++) begin
                    a_mem[k][p][i] = (mode == 0) ? 8'd2 : 8'(k*16 + p*3 + i + 1);
                    b_mem[k][p][i] = (mode == 0) ? 8'd2 : 8'(i + 2 + k);
                end
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
        delay[0] = d0; delay[1] = d1; delay[2] = d2; delay[3] = d3;
    endtask

    task automatic push_job(input int np, input int len);
        for (int p = 0; p < np; p++)
            for (int k = 0; k < NUM_DP; k++)
                sb.push_back('{addr: 6'(p*NUM_DP + k), data: dot(k, p, len), pass: 4'(p)});
    endtask

    task automatic push_lit(input int np, input logic [31:0] val);
        for (int p = 0; p < np; p++)
            for (int k = 0; k < NUM_DP; k++)
                sb.push_back('{addr: 6'(p*NUM_DP + k), data: val, pass: 4'(p)});
    endtask

    task automatic start_job(input int np, input int len);
        @(negedge clk);
        busy_cnt = 0; start_rise = 0; start_hi = 0; ack_rise = 0; we_cnt = 0; stray = 0;
        go = 1'b1; n_pass = 4'(np); vec_len = 4'(len);
        @(negedge clk);
        go = 1'b0;
        check("busy_on_accept", 32'(busy), 32'd1);
        check("err_cleared_on_go", 32'(err), 32'd0);
    endtask

    task automatic finish_job(input int max, input bit go_at_done, input int starts_exp,
                              input int we_exp, input int err_exp, input int acks_exp);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        if (go_at_done) begin
            go = 1'b1; n_pass = 4'd2;
        end
        @(negedge clk);
        go = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        #1;
        check("ticks_vs_busy", ticks, 32'(busy_cnt));
        check("err_flag", 32'(err), 32'(err_exp));
        check("start_count", 32'(start_rise), 32'(starts_exp));
        check("ack_count", 32'(ack_rise), 32'(acks_exp));
        check("write_count", 32'(we_cnt), 32'(we_exp));
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("stray_writes", 32'(stray), 32'd0);
        if (go_at_done) begin
            @(negedge clk);
            check("go_at_done_ignored", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0; go = 1'b0; n_pass = '0; vec_len = '0; eng_clr = 1'b1;
        for (int k = 0; k < NUM_DP; k++) stuck[k] = 1'b0;
        set_delays(0, 0, 0, 0);
        fill(0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1; eng_clr = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_start_mm", 32'(bus.start_mm), 32'd0);
        check("rst_ack", 32'(bus.ack_ticks), 32'd0);
        check("rst_we", 32'(bus.res_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ticks", ticks, 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);

        // single pass, all operands 2, length 3 -> each result 12
        push_lit(1, 32'd12);
        start_job(1, 3);
        finish_job(100, 1'b0, 1, 4, 0, 1);

        // three passes with a go pulse mid-job and one coinciding with done
        fill(1);
        push_job(3, 4);
        start_job(3, 4);
        repeat (8) @(negedge clk);
        go = 1'b1; n_pass = 4'd1; vec_len = 4'd2;
        @(negedge clk);
        go = 1'b0;
        finish_job(300, 1'b1, 3, 12, 0, 3);

        // staggered engine completion
        set_delays(0, 5, 9, 2);
        push_job(2, 3);
        start_job(2, 3);
        finish_job(200, 1'b0, 2, 8, 0, 2);
        set_delays(0, 0, 0, 0);

        // zero passes: FIN follows the accepting edge directly
        start_job(0, 3);
        check("np0_done_next_cycle", 32'(done), 32'd1);
        finish_job(10, 1'b0, 0, 0, 0, 0);
        check("np0_ticks", ticks, 32'd1);

        // zero-length vectors
        push_lit(1, 32'd0);
        start_job(1, 0);
        finish_job(100, 1'b0, 1, 4, 0, 1);

        // timeout: engine 2 never finishes; GO + 16 WAIT_DONE cycles of start_mm
        stuck[2] = 1'b1;
        start_job(1, 3);
        finish_job(100, 1'b0, 1, 0, 1, 0);
        check("timeout_start_hi", 32'(start_hi), 32'd17);
        @(negedge clk); eng_clr = 1'b1; stuck[2] = 1'b0;
        @(negedge clk); eng_clr = 1'b0;
        push_job(1, 2);
        start_job(1, 2);
        finish_job(100, 1'b0, 1, 4, 0, 1);

        // async reset in the middle of write-back
        push_job(2, 3);
        start_job(2, 3);
        for (int n = 0; n < 200 && we_cnt < 2; n++) begin
            @(negedge clk);
            #1;
        end
        #1 reset_n = 1'b0;
        #1;
        check("arst_start_mm", 32'(bus.start_mm), 32'd0);
        check("arst_ack", 32'(bus.ack_ticks), 32'd0);
        check("arst_we", 32'(bus.res_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_ticks", ticks, 32'd0);
        check("arst_pass_idx", 32'(bus.pass_idx), 32'd0);
        check("arst_res_addr", 32'(bus.res_addr), 32'd0);
        check("arst_res_data", bus.res_data, 32'd0);
        check("arst_a2", 32'(bus.a2), 32'd0);
        repeat (4) @(negedge clk);
        sb.delete();
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("no_write_after_reset", 32'(we_cnt), 32'd2);
        check("idle_after_reset", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
